// File: rtl/gpu_global_mem.sv
// gpu_global_mem: word-addressed global memory behind gpu_controller.
// Accepts one read and one write per cycle on byte addresses. Read data comes
// back after RD_LATENCY cycles with a single-cycle mem_rd_ack. Misaligned and
// out-of-range requests are flagged with a mem_err pulse and counted.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   mem_wr_en    write request (one word)
//   mem_wr_addr  write byte address
//   mem_wr_data  write data
//   mem_rd_en    read request (one word)
//   mem_rd_addr  read byte address
//   mem_rd_data  read data, non-zero only while mem_rd_ack is high
//   mem_rd_ack   one pulse per accepted read, RD_LATENCY cycles later
//   mem_err      pulse the cycle after a bad read and/or write address
//   err_cnt      saturating count of bad requests
module gpu_global_mem #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int MEM_WORDS  = 4096,
  parameter int RD_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_wr_en,
  input  logic [addr_width-1:0] mem_wr_addr,
  input  logic [data_width-1:0] mem_wr_data,
  input  logic                  mem_rd_en,
  input  logic [addr_width-1:0] mem_rd_addr,
  output logic [data_width-1:0] mem_rd_data,
  output logic                  mem_rd_ack,
  output logic                  mem_err,
  output logic [15:0]           err_cnt
);

  localparam int WORD_W = addr_width - 2;
  localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [WORD_W-1:0]     rd_word;
  logic [WORD_W-1:0]     wr_word;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic                  rd_oor;
  logic                  wr_oor;
  logic                  rd_bad;
  logic                  wr_bad;
  logic [16:0]           cnt_sum;

  logic [data_width-1:0] mem [MEM_WORDS];
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [data_width-1:0] pipe_data [RD_LATENCY];

  // Address bits [1:0] never select anything; they only make a request bad.
  assign rd_word = mem_rd_addr[addr_width-1:2];
  assign wr_word = mem_wr_addr[addr_width-1:2];
  assign rd_idx  = rd_word[IDX_W-1:0];
  assign wr_idx  = wr_word[IDX_W-1:0];
  assign rd_oor  = rd_word >= WORD_W'(MEM_WORDS);
  assign wr_oor  = wr_word >= WORD_W'(MEM_WORDS);
  assign rd_bad  = mem_rd_en & (rd_oor | (mem_rd_addr[1:0] != 2'b00));
  assign wr_bad  = mem_wr_en & (wr_oor | (mem_wr_addr[1:0] != 2'b00));

  // A read and a write on the same edge may hit both bad paths: add both.
  assign cnt_sum = {1'b0, err_cnt} + 17'(rd_bad) + 17'(wr_bad);

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_wr_en && !wr_oor) begin
      mem[wr_idx] <= mem_wr_data;
    end
  end

  // Stage 0 samples the array with the pre-write contents, which gives
  // read-before-write for a same-edge read and write of one word. Idle or
  // out-of-range slots carry zero so the output never shows stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
      mem_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      pipe_vld[0]  <= mem_rd_en;
      pipe_data[0] <= (mem_rd_en && !rd_oor) ? mem[rd_idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
      mem_err <= rd_bad | wr_bad;
      err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign mem_rd_ack  = pipe_vld[RD_LATENCY-1];
  assign mem_rd_data = pipe_data[RD_LATENCY-1];

endmodule
